// File: rtl/gf_2to128_pkg.sv
// Shared constants and types for the digit-serial GF(2^128) GHASH multiplier.
package gf_2to128_pkg;

  localparam int NB_DATA_GF = 128;

  // Reduction constant for x^128 + x^7 + x^2 + x + 1 in GCM (reflected) bit order
  localparam logic [NB_DATA_GF-1:0] R_X = {8'he1, 120'd0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n_steps);
    return (n_steps <= 2) ? 1 : $clog2(n_steps);
  endfunction

endpackage

// File: rtl/gf_2to128_digit_step.sv
// Combinational block applying NB_DIGIT shift-and-add steps of the GCM multiply.
module gf_2to128_digit_step
  import gf_2to128_pkg::*;
#(
  parameter int NB_DIGIT = 8
) (
  input  logic [NB_DATA_GF-1:0] z,
  input  logic [NB_DATA_GF-1:0] v,
  input  logic [NB_DIGIT-1:0]   x_digit,
  output logic [NB_DATA_GF-1:0] z_next,
  output logic [NB_DATA_GF-1:0] v_next
);

  // Digit MSB is the lowest-degree X coefficient, so it is consumed first
  always_comb begin
    z_next = z;
    v_next = v;
    for (int i = NB_DIGIT - 1; i >= 0; i--) begin
      if (x_digit[i]) begin
        z_next = z_next ^ v_next;
      end
      v_next = (v_next >> 1) ^ (v_next[0] ? R_X : '0);
    end
  end

endmodule

// File: rtl/gf_2to128_multiplier_digit_serial.sv
// Digit-serial GF(2^128) multiplier with valid/ready handshake and GHASH accumulate mode.
module gf_2to128_multiplier_digit_serial
  import gf_2to128_pkg::*;
#(
  parameter int NB_DATA  = 128,
  parameter int NB_DIGIT = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic [NB_DATA-1:0] i_data_h,
  input  logic               i_mode,
  input  logic               i_clear_acc,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data_z
);

  localparam bit BAD_CONF = (NB_DATA != NB_DATA_GF) || (NB_DIGIT < 1) ||
                            (NB_DIGIT > NB_DATA) || ((NB_DATA % NB_DIGIT) != 0);
  localparam int N_STEPS = NB_DATA / NB_DIGIT;
  localparam int CNT_W   = cnt_width(N_STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_STEPS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [NB_DATA-1:0] op_q, z_q, v_q, acc_q, data_z_q;
  logic               mode_q;
  logic [NB_DATA-1:0] z_step, v_step;
  logic               accept, last_step;

  assign o_ready   = !BAD_CONF && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready));
  assign o_valid   = (state_q == ST_DONE);
  assign o_data_z  = data_z_q;
  assign accept    = i_valid && o_ready;
  assign last_step = (cnt_q == LAST_CNT);

  gf_2to128_digit_step #(
    .NB_DIGIT(NB_DIGIT)
  ) u_step (
    .z      (z_q),
    .v      (v_q),
    .x_digit(op_q[NB_DATA-1 -: NB_DIGIT]),
    .z_next (z_step),
    .v_next (v_step)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accepting in DONE restarts RUN directly so back-to-back requests see no bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: begin
        if (accept) begin
          state_d = ST_RUN;
        end else if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      z_q      <= '0;
      v_q      <= '0;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      data_z_q <= '0;
    end else if (accept) begin
      op_q   <= (i_mode && !i_clear_acc) ? (i_data_x ^ acc_q) : i_data_x;
      v_q    <= i_data_h;
      z_q    <= '0;
      mode_q <= i_mode;
      cnt_q  <= '0;
    end else if (state_q == ST_RUN) begin
      op_q  <= op_q << NB_DIGIT;
      z_q   <= z_step;
      v_q   <= v_step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) begin
        data_z_q <= z_step;
        if (mode_q) begin
          acc_q <= z_step;
        end
      end
    end
  end

endmodule
